// File: rtl/cpu_stack_unit.sv
// LIFO stack held in a DEPTH x DATA_W register array indexed by the entry count.
// Provides the top two entries, occupancy flags and sticky overflow/underflow flags.
module cpu_stack_unit #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] top,
    output logic [DATA_W-1:0] next,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              is_empty, is_full, has_two;
    logic [IDX_W-1:0]  top_idx, next_idx;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign has_two  = (count_q >= CNT_W'(2));
    assign top_idx  = IDX_W'(count_q - CNT_W'(1));
    assign next_idx = IDX_W'(count_q - CNT_W'(2));

    // Next-state decode; rst outranks clr, clr outranks push/pop.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_en   = 1'b0;
        wr_idx  = IDX_W'(count_q);
        if (rst || clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (push && pop) begin
            wr_en = 1'b1;
            if (is_empty) begin
                wr_idx  = '0;
                count_d = CNT_W'(1);
            end else begin
                // Replace the top in place; occupancy is unchanged.
                wr_idx = top_idx;
            end
        end else if (push) begin
            if (is_full) begin
                ovf_d = 1'b1;
            end else begin
                wr_en   = 1'b1;
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop) begin
            if (is_empty) begin
                unf_d = 1'b1;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is not reset; the output decode hides entries beyond the count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= din;
        end
    end

    assign top       = is_empty ? '0 : mem_q[top_idx];
    assign next      = has_two ? mem_q[next_idx] : '0;
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
